// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle sequencer for the two-memory CPU
module mc_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int OP_W    = 4,
  parameter int RD_LAT  = 1,
  parameter int ALU_LAT = 1,
  parameter int OP_JMP  = 14,
  parameter int OP_BRZ  = 13,
  parameter int OP_HALT = 15,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              halted,
  output logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] res,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] addrI,
  input  logic [DATA_W-1:0] doutI,
  output logic [ADDR_W-1:0] pc,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [3:0] {
    IDLE, FETCH, WAIT_I, DECODE, WAIT_A, READ_A, WAIT_B, EXEC, WAIT_X, WRITE, HALT
  } state_t;

  // Instruction fields sit at the top of the word; a word narrower than the
  // fields is treated as zero-padded on the right.
  localparam int IW = OP_W + 3 * ADDR_W;
  localparam int PW = (DATA_W >= IW) ? DATA_W : IW;
  localparam int FS = PW - IW;

  // Wait states are entered with the counter preset to latency-1.
  localparam logic [2:0] RD_M1  = 3'(RD_LAT - 1);
  localparam logic [2:0] ALU_M1 = (ALU_LAT > 0) ? 3'(ALU_LAT - 1) : 3'd0;

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, addr_q, addr_d, addr_i_q, addr_i_d;
  logic [ADDR_W-1:0]  fa_q, fa_d, fb_q, fb_d, fd_q, fd_d;
  logic [OP_W-1:0]    op_q, op_d, opc_q, opc_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, din_q, din_d, opa_q, opa_d;
  logic               we_q, we_d, halted_q, halted_d;
  logic [CNT_W-1:0]   retired_q, retired_d, ret_inc;
  logic [PW-1:0]      ins;
  logic [OP_W-1:0]    f_op;
  logic [ADDR_W-1:0]  f_fa, f_fb, f_fd;

  assign ins  = PW'(doutI) << (PW - DATA_W);
  assign f_op = OP_W'(ins >> (FS + 3 * ADDR_W));
  assign f_fa = ADDR_W'(ins >> (FS + 2 * ADDR_W));
  assign f_fb = ADDR_W'(ins >> (FS + ADDR_W));
  assign f_fd = ADDR_W'(ins >> FS);

  // Saturating retire count: sticks at all-ones.
  assign ret_inc = (&retired_q) ? retired_q : retired_q + CNT_W'(1);

  // Next-state and next-output logic of the sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    addr_i_d  = addr_i_q;
    fa_d      = fa_q;
    fb_d      = fb_q;
    fd_d      = fd_q;
    op_d      = op_q;
    opc_d     = opc_q;
    a_d       = a_q;
    b_d       = b_q;
    din_d     = din_q;
    opa_d     = opa_q;
    we_d      = 1'b0;
    halted_d  = halted_q;
    retired_d = retired_q;
    unique case (state_q)
      IDLE: if (run) state_d = FETCH;
      FETCH: begin
        addr_i_d = pc_q;
        pc_d     = pc_q + ADDR_W'(1);
        cnt_d    = RD_M1;
        state_d  = WAIT_I;
      end
      WAIT_I: if (cnt_q == 3'd0) state_d = DECODE; else cnt_d = cnt_q - 3'd1;
      DECODE: begin
        opc_d = f_op;
        fa_d  = f_fa;
        fb_d  = f_fb;
        fd_d  = f_fd;
        if (f_op == OP_W'(OP_HALT)) begin
          halted_d = 1'b1;
          state_d  = HALT;
        end else if (f_op == OP_W'(OP_JMP)) begin
          pc_d      = f_fa;
          retired_d = ret_inc;
          state_d   = FETCH;
        end else begin
          addr_d  = f_fa;
          cnt_d   = RD_M1;
          state_d = WAIT_A;
        end
      end
      WAIT_A: if (cnt_q == 3'd0) state_d = READ_A; else cnt_d = cnt_q - 3'd1;
      READ_A: begin
        opa_d = dout;
        if (opc_q == OP_W'(OP_BRZ)) begin
          if (dout == '0) pc_d = fb_q;
          retired_d = ret_inc;
          state_d   = FETCH;
        end else begin
          addr_d  = fb_q;
          cnt_d   = RD_M1;
          state_d = WAIT_B;
        end
      end
      WAIT_B: if (cnt_q == 3'd0) state_d = EXEC; else cnt_d = cnt_q - 3'd1;
      EXEC: begin
        a_d  = opa_q;
        b_d  = dout;
        op_d = opc_q;
        if (ALU_LAT > 0) begin
          cnt_d   = ALU_M1;
          state_d = WAIT_X;
        end else begin
          state_d = WRITE;
        end
      end
      WAIT_X: if (cnt_q == 3'd0) state_d = WRITE; else cnt_d = cnt_q - 3'd1;
      WRITE: begin
        we_d      = 1'b1;
        addr_d    = fd_q;
        din_d     = res;
        retired_d = ret_inc;
        state_d   = FETCH;
      end
      HALT: if (run) begin
        halted_d = 1'b0;
        state_d  = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset wins over any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pc_q      <= '0;
      addr_q    <= '0;
      addr_i_q  <= '0;
      fa_q      <= '0;
      fb_q      <= '0;
      fd_q      <= '0;
      op_q      <= '0;
      opc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      din_q     <= '0;
      opa_q     <= '0;
      we_q      <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      addr_i_q  <= addr_i_d;
      fa_q      <= fa_d;
      fb_q      <= fb_d;
      fd_q      <= fd_d;
      op_q      <= op_d;
      opc_q     <= opc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      din_q     <= din_d;
      opa_q     <= opa_d;
      we_q      <= we_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  assign halted  = halted_q;
  assign op      = op_q;
  assign a       = a_q;
  assign b       = b_q;
  assign we      = we_q;
  assign addr    = addr_q;
  assign din     = din_q;
  assign addrI   = addr_i_q;
  assign pc      = pc_q;
  assign retired = retired_q;

endmodule
